yarp_data_ram: RTL and testbench

Byte-addressable, word-organised data RAM for the YARP core, directly downstream of `yarp_data_mem`. It consumes that block's memory request bus and performs lane alignment: byte strobes and lane-replicated write data on stores, extraction of the addressed byte or half-word to bit 0 on loads. It adds a configurable number of wait states behind a request/done handshake and returns right-aligned raw read data. `yarp_data_mem` then sign- or zero-extends that data.

---
 rtl/yarp_pkg.sv | 16 +
 rtl/yarp_data_ram_if.sv | 38 +++
 rtl/yarp_dmem_lane_align.sv | 39 +++
 rtl/yarp_data_ram.sv | 138 +++++++++++++
 tb/tb_yarp_data_ram.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/yarp_pkg.sv
// Shared YARP types: memory access size encoding and the data RAM FSM states.
package yarp_pkg;

    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b11
    } access_byte_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS
    } dmem_state_t;

endpackage

// File: rtl/yarp_data_ram_if.sv
// Request/response bus between yarp_data_mem (master) and yarp_data_ram (slave).
interface yarp_data_ram_if;

    logic        data_mem_req_i;
    logic [31:0] data_mem_addr_i;
    logic [1:0]  data_mem_byte_en_i;
    logic        data_mem_wr_i;
    logic [31:0] data_mem_wr_data_i;
    logic        mem_busy_o;
    logic        mem_done_o;
    logic        mem_err_o;
    logic [31:0] mem_rd_data_o;

    modport master (
        output data_mem_req_i,
        output data_mem_addr_i,
        output data_mem_byte_en_i,
        output data_mem_wr_i,
        output data_mem_wr_data_i,
        input  mem_busy_o,
        input  mem_done_o,
        input  mem_err_o,
        input  mem_rd_data_o
    );

    modport slave (
        input  data_mem_req_i,
        input  data_mem_addr_i,
        input  data_mem_byte_en_i,
        input  data_mem_wr_i,
        input  data_mem_wr_data_i,
        output mem_busy_o,
        output mem_done_o,
        output mem_err_o,
        output mem_rd_data_o
    );

endinterface

// File: rtl/yarp_dmem_lane_align.sv
// Byte-lane steering for the data RAM: store strobes/replication, load extraction,
// and alignment checking for half and word accesses.
module yarp_dmem_lane_align
    import yarp_pkg::*;
(
    input  access_byte_t size,
    input  logic [1:0]   addr_lo,
    input  logic [31:0]  wr_data,
    input  logic [31:0]  rd_word,
    output logic [3:0]   strobe,
    output logic [31:0]  wr_word,
    output logic [31:0]  rd_data,
    output logic         misalign
);

    always_comb begin
        strobe   = 4'hF;
        wr_word  = wr_data;
        rd_data  = rd_word;
        misalign = 1'b0;
        case (size)
            BYTE: begin
                strobe  = 4'b0001 << addr_lo;
                wr_word = {4{wr_data[7:0]}};
                rd_data = {24'h0, rd_word[{addr_lo, 3'b000} +: 8]};
            end
            HALF_WORD: begin
                strobe   = 4'b0011 << addr_lo;
                wr_word  = {2{wr_data[15:0]}};
                rd_data  = {16'h0, addr_lo[1] ? rd_word[31:16] : rd_word[15:0]};
                misalign = addr_lo[0];
            end
            default: begin
                misalign = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/yarp_data_ram.sv
// Word-organised, byte-addressable data RAM with configurable wait states behind
// a req/done handshake; returns right-aligned raw load data.
module yarp_data_ram
    import yarp_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    yarp_data_ram_if.slave bus
);

    localparam int          IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD  = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;

    dmem_state_t  state_reg, state_next;
    logic [3:0]   cnt_reg, cnt_next;
    logic [31:0]  addr_reg;
    access_byte_t size_reg;
    logic         wr_reg;
    logic [31:0]  wr_data_reg;
    logic [31:0]  rd_data_reg;
    logic [31:0]  rd_word_reg;

    logic [31:0]  mem [DEPTH_WORDS];

    logic         accept;
    logic [31:0]  offset;
    logic         range_err;
    logic         misalign;
    logic         access_err;
    logic         wr_en;
    logic [IDX_W-1:0] word_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [3:0]   strobe;
    logic [31:0]  wr_word;
    logic [31:0]  aligned_rd;

    assign accept = (state_reg == IDLE) && bus.data_mem_req_i;

    // BASE_ADDR is aligned to the array span, so the index bits need no subtraction.
    assign offset     = addr_reg - BASE_ADDR;
    assign range_err  = {1'b0, offset} >= SPAN_BYTES;
    assign access_err = range_err || misalign;
    assign word_idx   = addr_reg[IDX_W+1:2];
    assign wr_en      = (state_reg == ACCESS) && wr_reg && !access_err;

    // While idle the read port follows the incoming address so the word is
    // already registered by the time ACCESS begins, even with zero wait states.
    assign rd_idx = (state_reg == IDLE) ? bus.data_mem_addr_i[IDX_W+1:2] : word_idx;

    yarp_dmem_lane_align u_lane_align (
        .size     (size_reg),
        .addr_lo  (addr_reg[1:0]),
        .wr_data  (wr_data_reg),
        .rd_word  (rd_word_reg),
        .strobe   (strobe),
        .wr_word  (wr_word),
        .rd_data  (aligned_rd),
        .misalign (misalign)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (bus.data_mem_req_i) begin
                    if (WAIT_STATES == 0) begin
                        state_next = ACCESS;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = ACCESS;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ACCESS: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= 4'd0;
            addr_reg    <= 32'h0;
            size_reg    <= BYTE;
            wr_reg      <= 1'b0;
            wr_data_reg <= 32'h0;
            rd_data_reg <= 32'h0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                addr_reg    <= bus.data_mem_addr_i;
                size_reg    <= access_byte_t'(bus.data_mem_byte_en_i);
                wr_reg      <= bus.data_mem_wr_i;
                wr_data_reg <= bus.data_mem_wr_data_i;
            end
            if ((state_reg == ACCESS) && (access_err || !wr_reg)) begin
                rd_data_reg <= access_err ? 32'h0 : aligned_rd;
            end
        end
    end

    // Array has no reset so it maps onto block RAM with byte write enables.
    always_ff @(posedge clk) begin
        rd_word_reg <= mem[rd_idx];
        if (wr_en) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (strobe[lane]) begin
                    mem[word_idx][lane*8 +: 8] <= wr_word[lane*8 +: 8];
                end
            end
        end
    end

    assign bus.mem_busy_o    = (state_reg != IDLE);
    assign bus.mem_done_o    = (state_reg == ACCESS);
    assign bus.mem_err_o     = (state_reg == ACCESS) && access_err;
    assign bus.mem_rd_data_o = rd_data_reg;

endmodule

// File: tb/tb_yarp_data_ram.sv
// Randomised bench for yarp_data_ram against a byte-array memory model; two
// instances cover one-wait-state and zero-wait-state configurations.
module tb_yarp_data_ram;

    localparam logic [1:0]  SZ_B   = 2'b00;
    localparam logic [1:0]  SZ_H   = 2'b01;
    localparam logic [1:0]  SZ_W   = 2'b11;
    localparam logic [31:0] A_BASE = 32'h0000_0000;
    localparam int          A_WDS  = 64;
    localparam logic [31:0] B_BASE = 32'h8000_0000;
    localparam int          B_WDS  = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    yarp_data_ram_if bus_a();
    yarp_data_ram_if bus_b();

    yarp_data_ram #(.DEPTH_WORDS(A_WDS), .BASE_ADDR(A_BASE), .WAIT_STATES(1)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    yarp_data_ram #(.DEPTH_WORDS(B_WDS), .BASE_ADDR(B_BASE), .WAIT_STATES(0)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    logic [7:0]  mdl_a [A_WDS*4];
    logic [7:0]  mdl_b [B_WDS*4];
    logic [31:0] exp_rd_a = 32'h0;
    logic [31:0] exp_rd_b = 32'h0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mdl_rd(input int sel, input int o);
        return sel != 0 ? mdl_b[o] : mdl_a[o];
    endfunction

    task automatic mdl_wr(input int sel, input int o, input logic [7:0] v);
        if (sel != 0) mdl_b[o] = v;
        else          mdl_a[o] = v;
    endtask

    task automatic drive(input int sel, input logic req, input logic [31:0] addr,
                         input logic [1:0] size, input logic wr, input logic [31:0] wdata);
        if (sel != 0) begin
            bus_b.data_mem_req_i = req; bus_b.data_mem_addr_i = addr;
            bus_b.data_mem_byte_en_i = size; bus_b.data_mem_wr_i = wr;
            bus_b.data_mem_wr_data_i = wdata;
        end else begin
            bus_a.data_mem_req_i = req; bus_a.data_mem_addr_i = addr;
            bus_a.data_mem_byte_en_i = size; bus_a.data_mem_wr_i = wr;
            bus_a.data_mem_wr_data_i = wdata;
        end
    endtask

    task automatic sample(input int sel, output logic b, output logic d, output logic e,
                          output logic [31:0] r);
        if (sel != 0) begin
            b = bus_b.mem_busy_o; d = bus_b.mem_done_o; e = bus_b.mem_err_o; r = bus_b.mem_rd_data_o;
        end else begin
            b = bus_a.mem_busy_o; d = bus_a.mem_done_o; e = bus_a.mem_err_o; r = bus_a.mem_rd_data_o;
        end
    endtask

    // One complete transaction: drive, time it, then compare against the model.
    task automatic do_op(input int sel, input logic [31:0] addr, input logic [1:0] size,
                         input logic wr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic err);
        int ws, done_cyc, busy_n, nbytes, off;
        logic [31:0] base, exp_rd, rel;
        logic [32:0] span;
        logic e_err, hold, b, d, e;
        logic [31:0] r;
        ws     = (sel != 0) ? 0 : 1;
        base   = (sel != 0) ? B_BASE : A_BASE;
        span   = (sel != 0) ? 33'(B_WDS * 4) : 33'(A_WDS * 4);
        rel    = addr - base;
        nbytes = (size == SZ_B) ? 1 : (size == SZ_H) ? 2 : 4;
        e_err  = ((size == SZ_H) && addr[0]) || ((size == SZ_W) && (addr[1:0] != 2'b00)) ||
                 ({1'b0, rel} >= span);
        hold   = 1'($urandom_range(0, 1));
        drive(sel, 1'b1, addr, size, wr, wdata);
        @(posedge clk); #1;
        // Requester changes its mind after the accept; the transaction must finish as captured.
        if (!hold) drive(sel, 1'b0, $urandom, 2'($urandom), 1'($urandom), $urandom);
        done_cyc = 0; busy_n = 0; err = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            sample(sel, b, d, e, r);
            if (b) busy_n++;
            if (d) begin
                done_cyc = c;
                err = e;
                break;
            end
            @(posedge clk); #1;
        end
        drive(sel, 1'b0, 32'h0, SZ_B, 1'b0, 32'h0);
        check_val("done_lat", 32'(done_cyc), 32'(ws + 1));
        check_val("busy_cycles", 32'(busy_n), 32'(ws + 1));
        check_val("err", {31'h0, err}, {31'h0, e_err});
        @(posedge clk); #1;
        sample(sel, b, d, e, r);
        check_val("idle_after", {30'h0, b, d}, 32'h0);
        exp_rd = (sel != 0) ? exp_rd_b : exp_rd_a;
        off = int'(rel);
        if (e_err) begin
            exp_rd = 32'h0;
        end else if (wr) begin
            for (int k = 0; k < nbytes; k++) mdl_wr(sel, off + k, wdata[8*k +: 8]);
        end else begin
            exp_rd = 32'h0;
            for (int k = 0; k < nbytes; k++) exp_rd[8*k +: 8] = mdl_rd(sel, off + k);
        end
        if (sel != 0) exp_rd_b = exp_rd;
        else          exp_rd_a = exp_rd;
        rd = r;
        check_val("rd_data", r, exp_rd);
        txn_no++;
        $display("txn %0d dut%0d %s sz=%0d addr=%08h wdata=%08h rd=%08h err=%0b",
                 txn_no, sel, wr ? "ST" : "LD", size, addr, wdata, r, err);
    endtask

    task automatic rand_op(input int sel);
        logic [31:0] base, addr, rd;
        int wds, pick;
        logic [1:0] size;
        logic err;
        base = (sel != 0) ? B_BASE : A_BASE;
        wds  = (sel != 0) ? B_WDS : A_WDS;
        pick = $urandom_range(0, 9);
        if (pick == 0)      addr = base + 32'(wds * 4) + 32'($urandom_range(0, 15));
        else if (pick == 1) addr = $urandom;
        else                addr = base + 32'($urandom_range(0, wds * 4 - 1));
        pick = $urandom_range(0, 2);
        size = (pick == 0) ? SZ_B : (pick == 1) ? SZ_H : SZ_W;
        do_op(sel, addr, size, 1'($urandom), $urandom, rd, err);
    endtask

    logic [31:0] rd;
    logic        err;
    logic        b, d, e;
    logic [31:0] r;

    initial begin
        drive(0, 1'b0, 32'h0, SZ_B, 1'b0, 32'h0);
        drive(1, 1'b0, 32'h0, SZ_B, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        sample(0, b, d, e, r);
        check_val("reset_a", {b, d, e, 29'h0} | r, 32'h0);
        sample(1, b, d, e, r);
        check_val("reset_b", {b, d, e, 29'h0} | r, 32'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Fill every word through the bus so the model is fully defined.
        for (int i = 0; i < A_WDS; i++) do_op(0, A_BASE + 32'(i * 4), SZ_W, 1'b1, $urandom, rd, err);
        for (int i = 0; i < B_WDS; i++) do_op(1, B_BASE + 32'(i * 4), SZ_W, 1'b1, $urandom, rd, err);

        do_op(0, 32'h10, SZ_W, 1'b1, 32'hDEADBEEF, rd, err);
        do_op(0, 32'h10, SZ_W, 1'b0, 32'h0, rd, err);
        check_val("plan_word", rd, 32'hDEADBEEF);

        do_op(0, 32'h20, SZ_B, 1'b1, 32'h11, rd, err);
        do_op(0, 32'h21, SZ_B, 1'b1, 32'h22, rd, err);
        do_op(0, 32'h22, SZ_B, 1'b1, 32'h33, rd, err);
        do_op(0, 32'h23, SZ_B, 1'b1, 32'h44, rd, err);
        do_op(0, 32'h20, SZ_W, 1'b0, 32'h0, rd, err);
        check_val("plan_bytes", rd, 32'h44332211);
        do_op(0, 32'h22, SZ_H, 1'b0, 32'h0, rd, err);
        check_val("plan_half", rd, 32'h00004433);

        do_op(0, 32'h23, SZ_B, 1'b1, 32'hFFFF_FF80, rd, err);
        do_op(0, 32'h23, SZ_B, 1'b0, 32'h0, rd, err);
        check_val("plan_no_sext", rd, 32'h00000080);

        do_op(0, 32'h31, SZ_H, 1'b1, 32'h0000_5A5A, rd, err);
        check_val("plan_half_mis", {31'h0, err}, 32'h1);
        do_op(0, 32'h42, SZ_W, 1'b0, 32'h0, rd, err);
        check_val("plan_word_mis", {31'h0, err}, 32'h1);
        check_val("plan_err_rd", rd, 32'h0);
        do_op(0, 32'h30, SZ_W, 1'b0, 32'h0, rd, err);

        do_op(0, A_BASE + 32'(A_WDS * 4), SZ_W, 1'b1, 32'h1234_5678, rd, err);
        check_val("plan_range_a", {31'h0, err}, 32'h1);
        do_op(1, B_BASE + 32'(B_WDS * 4), SZ_B, 1'b1, 32'h0000_00AA, rd, err);
        check_val("plan_range_b", {31'h0, err}, 32'h1);
        do_op(1, B_BASE + 32'h8, SZ_W, 1'b1, 32'hA5A5_0F0F, rd, err);
        do_op(1, B_BASE + 32'h8, SZ_W, 1'b0, 32'h0, rd, err);
        check_val("plan_ws0_word", rd, 32'hA5A5_0F0F);

        for (int i = 0; i < 200; i++) rand_op(int'($urandom_range(0, 1)));

        // Reset while a store sits in WAIT: store dropped, outputs cleared.
        drive(0, 1'b1, 32'h50, SZ_W, 1'b1, 32'hCAFE_F00D);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        sample(0, b, d, e, r);
        check_val("rst_mid_a", {b, d, e, 29'h0} | r, 32'h0);
        sample(1, b, d, e, r);
        check_val("rst_mid_b", r, 32'h0);
        drive(0, 1'b0, 32'h0, SZ_B, 1'b0, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        exp_rd_a = 32'h0;
        exp_rd_b = 32'h0;
        do_op(0, 32'h50, SZ_W, 1'b0, 32'h0, rd, err);

        for (int i = 0; i < 40; i++) rand_op(int'($urandom_range(0, 1)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
